tx_prbs_gen: RTL and testbench



---
 rtl/tx_prbs_gen_if.sv | 20 ++
 rtl/tx_prbs_gen.sv | 133 +++++++++++++
 tb/tb_tx_prbs_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_prbs_gen_if.sv
// Pattern-generator control/status bundle: run/mode/error-inject in, serial stream and status out.
interface tx_prbs_gen_if;
  logic       en;
  logic [1:0] mode;
  logic       inj_err;
  logic       out;
  logic       sync;
  logic       active;
  logic [7:0] err_cnt;

  modport master (
    output en, mode, inj_err,
    input  out, sync, active, err_cnt
  );

  modport slave (
    input  en, mode, inj_err,
    output out, sync, active, err_cnt
  );
endinterface

// File: rtl/tx_prbs_gen.sv
// PRBS7/15/31 or 1010 clock-pattern TX source with period sync and single-bit error injection.
// First bit on out two edges after en (or a mode change) is sampled; no backpressure, free-running in RUN.
module tx_prbs_gen #(
  parameter logic [30:0] SEED         = 31'h7FFF_FFFF,
  parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
  input  logic         clk,
  input  logic         rst,
  tx_prbs_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q;
  logic [30:0] s, s_nxt;
  logic [30:0] cnt, last_cnt;
  logic [30:0] load_mask, seed_m;
  logic        nb, pat_bit;
  logic        out_q, sync_q, active_q;
  logic [7:0]  err_cnt_q;

  function automatic logic [30:0] mode_mask(input logic [1:0] m);
    case (m)
      2'd1:    return 31'h0000_7FFF;
      2'd2:    return 31'h7FFF_FFFF;
      default: return 31'h0000_007F;
    endcase
  endfunction

  always_comb begin
    nb       = 1'b0;
    last_cnt = 31'd1;
    case (mode_q)
      2'd0: begin
        nb       = s[6] ^ s[5];
        last_cnt = 31'd126;
      end
      2'd1: begin
        nb       = s[14] ^ s[13];
        last_cnt = 31'd32766;
      end
      2'd2: begin
        nb       = s[30] ^ s[27];
        last_cnt = 31'h7FFF_FFFE;
      end
      default: begin
        nb       = 1'b0;
        last_cnt = 31'd1;
      end
    endcase
    // Bits above the active polynomial length stay zero.
    s_nxt     = {s[29:0], nb} & mode_mask(mode_q);
    pat_bit   = (mode_q == 2'd3) ? cnt[0] : nb;
    load_mask = mode_mask(bus.mode);
    seed_m    = SEED & load_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (!bus.en)                   state_nxt = IDLE;
        else if (bus.mode != mode_q)   state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= DEFAULT_MODE;
      s         <= '0;
      cnt       <= '0;
      out_q     <= 1'b0;
      sync_q    <= 1'b0;
      active_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          out_q    <= 1'b0;
          sync_q   <= 1'b0;
          active_q <= 1'b0;
        end
        LOAD: begin
          s        <= (seed_m == 31'd0) ? load_mask : seed_m;
          cnt      <= '0;
          mode_q   <= bus.mode;
          out_q    <= 1'b0;
          sync_q   <= 1'b0;
          active_q <= 1'b1;
        end
        RUN: begin
          if (bus.inj_err && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
          if (state_nxt == RUN) begin
            s      <= s_nxt;
            cnt    <= (cnt == last_cnt) ? 31'd0 : cnt + 31'd1;
            out_q  <= pat_bit ^ bus.inj_err;
            sync_q <= (cnt == 31'd0);
          end else begin
            // Leaving RUN: the launched bit is suppressed, so a coincident inject is not visible.
            out_q    <= 1'b0;
            sync_q   <= 1'b0;
            active_q <= (state_nxt == LOAD);
          end
        end
        default: begin
          out_q  <= 1'b0;
          sync_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out     = out_q;
  assign bus.sync    = sync_q;
  assign bus.active  = active_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tx_prbs_gen.sv
// Directed/randomized bench for tx_prbs_gen against a bit-history recurrence model.
module tb_tx_prbs_gen;
  localparam logic [30:0] SEED0 = 31'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_prbs_gen_if b0();
  tx_prbs_gen_if b1();

  assign b1.en      = b0.en;
  assign b1.mode    = b0.mode;
  assign b1.inj_err = b0.inj_err;

  tx_prbs_gen #(.SEED(SEED0), .DEFAULT_MODE(2'd0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  tx_prbs_gen #(.SEED(31'd0), .DEFAULT_MODE(2'd0)) u_dut_s0 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int      checks = 0;
  int      errors = 0;
  bit      hist[$];
  int      midx;
  int      mmode;
  longint  mper;
  int      last_sync;
  int      ones;
  int      exp_err;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int taps_n(input int m);
    return (m == 0) ? 7 : (m == 1) ? 15 : 31;
  endfunction

  function automatic int taps_m(input int m);
    return (m == 0) ? 6 : (m == 1) ? 14 : 28;
  endfunction

  // Output bit t of a PRBS obeys a[t] = a[t-N] ^ a[t-M]; the seed supplies a[-N..-1].
  task automatic model_load(input int m);
    int          n;
    longint      mask;
    logic [30:0] sd;
    mmode     = m;
    midx      = 0;
    last_sync = -1;
    hist.delete();
    if (m == 3) begin
      mper = 2;
    end else begin
      n    = taps_n(m);
      mask = (longint'(1) << n) - 1;
      mper = mask;
      sd   = SEED0 & mask[30:0];
      if (sd == 31'd0) sd = mask[30:0];
      for (int k = n - 1; k >= 0; k--) hist.push_back(sd[k]);
    end
  endtask

  task automatic model_next(output bit b, output bit sy, output int idx);
    int sz;
    idx = midx;
    sy  = ((longint'(midx) % mper) == 0);
    if (mmode == 3) begin
      b = midx[0];
    end else begin
      sz = hist.size();
      b  = hist[sz - taps_n(mmode)] ^ hist[sz - taps_m(mmode)];
      hist.push_back(b);
      if (hist.size() > 40) void'(hist.pop_front());
    end
    midx++;
  endtask

  task automatic bump_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  task automatic run(input int n, input bit inj);
    bit eb, es;
    int idx;
    for (int i = 0; i < n; i++) begin
      b0.inj_err = inj;
      tick();
      b0.inj_err = 1'b0;
      model_next(eb, es, idx);
      if (inj) bump_err();
      chk_b("out", b0.out, eb ^ inj);
      chk_b("out_seed0", b1.out, eb ^ inj);
      chk_b("sync", b0.sync, es);
      chk_b("active", b0.active, 1'b1);
      if (b0.sync === 1'b1) begin
        if (last_sync >= 0) chk_n("sync_gap", 32'(idx - last_sync), 32'(mper));
        last_sync = idx;
      end
      if (b0.out === 1'b1) ones++;
    end
  endtask

  // Edge k enters LOAD, edge k+1 enters RUN; pattern starts at edge k+2.
  task automatic start(input int m, input logic act_k, input bit inj);
    b0.mode    = 2'(m);
    b0.inj_err = inj;
    tick();
    b0.inj_err = 1'b0;
    if (inj) bump_err();
    chk_b("load_out", b0.out, 1'b0);
    chk_b("load_sync", b0.sync, 1'b0);
    chk_b("load_active", b0.active, act_k);
    chk_n("load_err_cnt", {24'd0, b0.err_cnt}, 32'(exp_err));
    tick();
    chk_b("run0_out", b0.out, 1'b0);
    chk_b("run0_active", b0.active, 1'b1);
    model_load(m);
  endtask

  task automatic check_head();
    logic [13:0] golden;
    golden = 14'b00000010000011;
    for (int i = 0; i < 14; i++) begin
      run(1, 1'b0);
      chk_b("prbs7_head", b0.out, golden[13 - i]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    b0.en      = 1'b0;
    b0.mode    = 2'd0;
    b0.inj_err = 1'b0;
    exp_err    = 0;
    #3;
    chk_b("rst_out", b0.out, 1'b0);
    chk_b("rst_sync", b0.sync, 1'b0);
    chk_b("rst_active", b0.active, 1'b0);
    chk_n("rst_err_cnt", {24'd0, b0.err_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_b("idle_out", b0.out, 1'b0);
    chk_b("idle_active", b0.active, 1'b0);

    // PRBS7 from default seed: head, full period, then injected errors on bits 10 and 20.
    b0.en = 1'b1;
    start(0, 1'b0, 1'b0);
    ones = 0;
    check_head();
    run(113, 1'b0);
    chk_n("prbs7_ones", 32'(ones), 32'd64);
    run(10, 1'b0);
    run(1, 1'b1);
    run(9, 1'b0);
    run(1, 1'b1);
    run(106, 1'b0);
    chk_n("err_cnt_two", {24'd0, b0.err_cnt}, 32'd2);
    ones = 0;
    run(127, 1'b0);
    chk_n("clean_period_ones", 32'(ones), 32'd64);

    // Random-length stretch, then switch to clock pattern with a coincident inject.
    run(int'($urandom_range(5, 60)), 1'b0);
    start(3, 1'b1, 1'b1);
    chk_n("err_cnt_modechg", {24'd0, b0.err_cnt}, 32'd3);
    run(8, 1'b0);
    run(251, 1'b1);
    chk_n("err_cnt_254", {24'd0, b0.err_cnt}, 32'd254);
    run(49, 1'b1);
    chk_n("err_cnt_sat", {24'd0, b0.err_cnt}, 32'd255);
    for (int i = 0; i < 40; i++) run(1, 1'($urandom_range(0, 1)));
    chk_n("err_cnt_hold", {24'd0, b0.err_cnt}, 32'd255);

    // PRBS15 over a full period plus one bit, PRBS31 for 10k bits.
    start(1, 1'b1, 1'b0);
    run(32768, 1'b0);
    start(2, 1'b1, 1'b0);
    run(10000, 1'b0);

    // Drop en mid-stream, idle a few cycles, restart PRBS7 from the seed.
    b0.en = 1'b0;
    tick();
    chk_b("en_low_out", b0.out, 1'b0);
    chk_b("en_low_sync", b0.sync, 1'b0);
    chk_b("en_low_active", b0.active, 1'b0);
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
      tick();
      chk_b("idle_hold_out", b0.out, 1'b0);
    end
    b0.mode = 2'd0;
    b0.en   = 1'b1;
    start(0, 1'b0, 1'b0);
    check_head();
    run(20, 1'b0);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    exp_err = 0;
    chk_b("arst_out", b0.out, 1'b0);
    chk_b("arst_sync", b0.sync, 1'b0);
    chk_b("arst_active", b0.active, 1'b0);
    chk_n("arst_err_cnt", {24'd0, b0.err_cnt}, 32'd0);
    chk_b("arst_out_seed0", b1.out, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_b("post_rst_active", b0.active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
